lsu_ram_bridge: RTL
===================

Name: lsu_ram_bridge

Overview:
Load/store bridge between the core's memory-request handshake and the byte-banked single-port data RAM (size 00/01/10, posedge write, negedge-registered read). It does the following:
- accepts one request at a time;
- checks range, size and alignment;
- drives the RAM size, write-enable, address and write data;
- captures the RAM read data and returns it zero- or sign-extended with a one-cycle response pulse.

Parameters:
ADDR_BASE, 32'h2000_0000, byte address mapped to RAM location 0
ADDR_BITS, 10, RAM byte-address width; window is 2**ADDR_BITS bytes

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  bridge can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal
req_signed  input  1  load sign-extension enable
req_addr  input  32  byte address
req_wdata  input  32  store data, low-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  load result (0 for stores and faults)
resp_fault  output  1  qualifies resp_valid; access rejected
ram_size  output  2  RAM size select
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_BITS  RAM byte address
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data, zero-extended, updated on negedge

Behaviour:
- Reset is synchronous and active-high on rst, clock clk.
  - Reset values: state IDLE; req_ready = 0 during reset, 1 in the first cycle after reset; resp_valid = 0, resp_fault = 0, resp_rdata = 0; ram_we = 0, ram_size = 00, ram_addr = 0, ram_wdata = 0.
  - rst asserted in any state aborts the transaction; no response is produced. A write in ACCESS may still land in RAM at that edge, since the RAM does not see rst on writes.
- All outputs are registered.
- States:
  - IDLE: req_ready = 1. On req_valid, latch the request.
    - If a fault condition holds, go to RESP with fault.
    - Otherwise load ram_size = req_size, ram_addr = req_addr - ADDR_BASE (low ADDR_BITS bits), ram_wdata = req_wdata, ram_we = req_write, and go to ACCESS.
  - ACCESS: one cycle.
    - RAM inputs are held stable for the whole cycle.
    - The RAM captures read data on the negedge inside this cycle and writes at the closing posedge.
    - At the closing posedge, latch ram_rdata for loads, drop ram_we, go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle with resp_rdata and resp_fault, then IDLE. There is no response backpressure.
- Latency, with the accept edge as cycle 0:
  - successful access: ACCESS in cycle 1, resp_valid in cycle 2;
  - fault: resp_valid in cycle 1, no RAM access, ram_we stays 0.
- Back-to-back: the next request is accepted in the cycle after RESP, giving a throughput of 1 request per 3 cycles.
- Fault conditions:
  - req_size = 11;
  - (req_addr - ADDR_BASE) >= 2**ADDR_BITS, including addresses below ADDR_BASE (unsigned wrap);
  - misalignment (half with addr[0] = 1, word with addr[1:0] != 0) when the optional feature is off.
- Load extension:
  - byte: bit 7 replicated into [31:8] if req_signed, else zero;
  - half: bit 15 replicated into [31:16] if req_signed, else zero;
  - word: passed through unchanged.
- Store: resp_rdata = 0, resp_fault = 0.

Optional Feature:
- Macro LSU_UNALIGNED_SPLIT_EN.
- Defined:
  - A misaligned half or word is executed as N = 2 or 4 sequential byte accesses (ram_size = 00) at offsets 0..N-1.
  - Each byte takes one ACCESS cycle, with a byte counter kept in ACCESS.
  - Store byte k uses req_wdata[8k+7:8k]; load byte k is placed at resp_rdata[8k+7:8k], then the extension rules apply.
  - The range check also covers offset + N-1; an out-of-range last byte faults before any RAM access.
  - Response arrives in cycle N+1 after accept.
- Undefined: misaligned accesses fault as described in Behaviour.

Test Plan:
- Word store 32'hDEADBEEF at 0x2000_0010, then word load at 0x2000_0010 → resp_rdata = 32'hDEADBEEF; resp_valid exactly 2 cycles after each accept; ram_we high for exactly 1 cycle.
- Byte store 8'h80 at 0x2000_0003, then signed byte load → 32'hFFFF_FF80; unsigned byte load → 32'h0000_0080. Half store 16'h8001 at 0x2000_0006, then signed half load → 32'hFFFF_8001.
- Load at 0x2000_0400, at 0x1FFF_FFFC, and with req_size = 11 → resp_fault = 1, resp_rdata = 0, resp_valid 1 cycle after accept, ram_we never asserted.
- Word load at 0x2000_0002:
  - without LSU_UNALIGNED_SPLIT_EN → fault;
  - with it, after byte stores 11/22/33/44 at 0x2000_0002..0x2000_0005 → 32'h44332211 in cycle 5 after accept.
  - With the macro, a word at 0x2000_03FE → fault.
- req_valid held high for 4 requests → req_ready low except in IDLE; accept edges exactly 3 cycles apart; responses in order.
- rst asserted during ACCESS of a load → no resp_valid; ram_we = 0 and req_ready = 0 while rst is high; req_ready = 1 in the first cycle after release; the next request completes normally.

Source files
------------

// File: rtl/lsu_ram_bridge.sv
// Load/store bridge from the core request handshake to the byte-banked data RAM.
// Optional macro LSU_UNALIGNED_SPLIT_EN turns misaligned half/word accesses into byte sequences.
//
//   state  | meaning
//   IDLE   | req_ready high, waiting for a request
//   ACCESS | RAM inputs held; read captured on negedge, write at closing posedge
//   RESP   | one-cycle response pulse
module lsu_ram_bridge #(
    parameter logic [31:0] ADDR_BASE = 32'h2000_0000,
    parameter int          ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_fault,
    output logic [1:0]           ram_size,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [31:0] WIN_LAST = (32'd1 << ADDR_BITS) - 32'd1;

    logic [1:0]  state;
    logic        is_write;
    logic        is_signed;
    logic [1:0]  size_q;
    logic [31:0] off;
    logic [1:0]  nbytes_m1;
    logic        misaligned;
    logic        out_of_range;
    logic        fault;
    logic [31:0] ld_data;

`ifdef LSU_UNALIGNED_SPLIT_EN
    logic        split_q;
    logic [1:0]  cnt;
    logic [1:0]  cnt_nx;
    logic [1:0]  last;
    logic [31:0] wdata_q;
    logic [31:0] acc_q;
    logic [31:0] merged;

    assign cnt_nx  = cnt + 2'd1;
    assign merged  = acc_q | ({24'b0, ram_rdata[7:0]} << {cnt, 3'b000});
    assign ld_data = split_q ? merged : ram_rdata;
`else
    assign ld_data = ram_rdata;
`endif

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                           input logic sgn);
        case (sz)
            2'b00:   return sgn ? {{24{d[7]}}, d[7:0]} : {24'b0, d[7:0]};
            2'b01:   return sgn ? {{16{d[15]}}, d[15:0]} : {16'b0, d[15:0]};
            default: return d;
        endcase
    endfunction

    // The range check covers the last byte touched, so a word straddling the
    // window end is rejected even when its first byte is inside.
    always_comb begin
        off = req_addr - ADDR_BASE;
        case (req_size)
            2'b01:   nbytes_m1 = 2'd1;
            2'b10:   nbytes_m1 = 2'd3;
            default: nbytes_m1 = 2'd0;
        endcase
        misaligned   = (req_size == 2'b01 && req_addr[0]) ||
                       (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        out_of_range = off > (WIN_LAST - {30'b0, nbytes_m1});
`ifdef LSU_UNALIGNED_SPLIT_EN
        fault = (req_size == 2'b11) || out_of_range;
`else
        fault = (req_size == 2'b11) || out_of_range || misaligned;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b0;
            is_write   <= 1'b0;
            is_signed  <= 1'b0;
            size_q     <= 2'b00;
            resp_valid <= 1'b0;
            resp_rdata <= 32'b0;
            resp_fault <= 1'b0;
            ram_size   <= 2'b00;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= 32'b0;
`ifdef LSU_UNALIGNED_SPLIT_EN
            split_q    <= 1'b0;
            cnt        <= 2'd0;
            last       <= 2'd0;
            wdata_q    <= 32'b0;
            acc_q      <= 32'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    resp_rdata <= 32'b0;
                    resp_fault <= 1'b0;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        is_write  <= req_write;
                        is_signed <= req_signed;
                        size_q    <= req_size;
                        if (fault) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                        end else begin
                            state    <= S_ACCESS;
                            ram_we   <= req_write;
                            ram_addr <= off[ADDR_BITS-1:0];
`ifdef LSU_UNALIGNED_SPLIT_EN
                            split_q   <= misaligned;
                            cnt       <= 2'd0;
                            last      <= nbytes_m1;
                            wdata_q   <= req_wdata;
                            acc_q     <= 32'b0;
                            ram_size  <= misaligned ? 2'b00 : req_size;
                            ram_wdata <= misaligned ? {24'b0, req_wdata[7:0]} : req_wdata;
`else
                            ram_size  <= req_size;
                            ram_wdata <= req_wdata;
`endif
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_ACCESS: begin
`ifdef LSU_UNALIGNED_SPLIT_EN
                    if (split_q && cnt != last) begin
                        cnt       <= cnt_nx;
                        acc_q     <= merged;
                        ram_addr  <= ram_addr + ADDR_BITS'(1);
                        ram_wdata <= {24'b0, wdata_q[{cnt_nx, 3'b000} +: 8]};
                    end else begin
`else
                    begin
`endif
                        ram_we     <= 1'b0;
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= is_write ? 32'b0 : extend(ld_data, size_q, is_signed);
                    end
                end
                S_RESP: begin
                    state      <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_rdata <= 32'b0;
                    resp_fault <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
